// File: rtl/bf_pkg.sv
// Shared opcode encodings and sequencer state type for the Brainfuck execution path.
package bf_pkg;

  localparam logic [2:0] INC  = 3'b111;
  localparam logic [2:0] DEC  = 3'b110;
  localparam logic [2:0] MOVR = 3'b101;
  localparam logic [2:0] MOVL = 3'b100;
  localparam logic [2:0] IF   = 3'b011;
  localparam logic [2:0] BACK = 3'b010;
  localparam logic [2:0] OUT  = 3'b001;
  localparam logic [2:0] NOP  = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    LOAD,
    EXEC,
    WB,
    OUT_WAIT,
    DONE
  } seq_state_t;

  // Opcodes whose result must be written back to the current data cell.
  function automatic logic is_rmw(logic [2:0] op);
    return (op == INC) || (op == DEC);
  endfunction

endpackage

// File: rtl/bf_exec_sequencer.sv
// Multi-cycle sequencer stepping the Brainfuck core through fetch, load, exec, writeback
// and an optional output handshake; owns the data pointer and the step watchdog.
module bf_exec_sequencer
  import bf_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned PC_W      = 8,
  parameter int unsigned MAX_STEPS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       step_count,
  input  logic [PC_W-1:0]   rom_pc,
  output logic              rom_en,
  input  logic [2:0]        rom_data,
  output logic              core_step,
  output logic [2:0]        core_opcode,
  output logic [ADDR_W-1:0] core_ram_addr,
  output logic [DATA_W-1:0] core_ram_val,
  input  logic [ADDR_W-1:0] core_next_addr,
  input  logic [DATA_W-1:0] core_next_val,
  input  logic              core_cout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] dp_q, dp_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [31:0]       step_q, step_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              error_q, error_d;
  logic              watchdog_hit;

  // The ROM is addressed by the core directly; the sequencer only gates the read.
  logic unused_rom_pc;
  assign unused_rom_pc = ^rom_pc;

  assign watchdog_hit = (MAX_STEPS != 0) && (step_q == MAX_STEPS);

  always_comb begin
    state_d    = state_q;
    dp_d       = dp_q;
    op_d       = op_q;
    val_d      = val_q;
    step_d     = step_q;
    out_data_d = out_data_q;
    error_d    = error_q;
    rom_en     = 1'b0;
    ram_rd     = 1'b0;
    ram_wr     = 1'b0;
    core_step  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        rom_en  = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        op_d = rom_data;
        if (rom_data == NOP) begin
          error_d = 1'b0;
          state_d = DONE;
        end else if (watchdog_hit) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          ram_rd  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        val_d   = ram_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        core_step = 1'b1;
        if (step_q != '1) step_d = step_q + 32'd1;
        state_d = WB;
      end
      WB: begin
        // While the core skips a loop body it echoes the loaded value, so this rewrite is benign.
        if (is_rmw(op_q)) ram_wr = 1'b1;
        dp_d = core_next_addr;
        if (core_cout) begin
          out_data_d = core_next_val;
          state_d    = OUT_WAIT;
        end else begin
          state_d = FETCH;
        end
      end
      OUT_WAIT: begin
        if (out_ready) state_d = FETCH;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dp_q       <= '0;
      op_q       <= '0;
      val_q      <= '0;
      step_q     <= '0;
      out_data_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dp_q       <= dp_d;
      op_q       <= op_d;
      val_q      <= val_d;
      step_q     <= step_d;
      out_data_q <= out_data_d;
      error_q    <= error_d;
    end
  end

  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = (state_q == DONE);
  assign error         = error_q;
  assign step_count    = step_q;
  assign core_opcode   = op_q;
  assign core_ram_addr = dp_q;
  assign core_ram_val  = val_q;
  assign ram_addr      = dp_q;
  assign ram_wdata     = core_next_val;
  assign out_valid     = (state_q == OUT_WAIT);
  assign out_data      = out_data_q;

  a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({rom_en, ram_rd, ram_wr}));

  a_out_hold: assert property (@(posedge clk)
    (out_valid && !out_ready && !rst) |=> (out_valid && $stable(out_data)));

endmodule
